// File: rtl/exec_retire_if.sv
`default_nettype none
// ============================================================================
// Module   : exec_retire_if
// Purpose  : Bundles the ALU-side op stream, the register-file writeback
//            stream and the architectural flags of the execute/retire stage.
// Revision : 1.0 - initial release
// ============================================================================
interface exec_retire_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    // ALU-side op stream
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_inst;
    logic [DATA_W-1:0] in_da;
    logic [DATA_W-1:0] in_db;
    logic [DATA_W-1:0] in_result;
    logic [REG_AW-1:0] in_rd;

    // Register-file writeback stream
    logic              out_valid;
    logic              out_ready;
    logic              out_we;
    logic [REG_AW-1:0] out_rd;
    logic [DATA_W-1:0] out_data;

    // Architectural flags {Z,S,C,O}
    logic [3:0]        flags;

    // Environment side: offers ops, accepts writebacks
    modport master (
        output in_valid, in_inst, in_da, in_db, in_result, in_rd, out_ready,
        input  in_ready, out_valid, out_we, out_rd, out_data, flags
    );

    // Stage side
    modport slave (
        input  in_valid, in_inst, in_da, in_db, in_result, in_rd, out_ready,
        output in_ready, out_valid, out_we, out_rd, out_data, flags
    );
endinterface
`default_nettype wire

// File: rtl/exec_retire_stage.sv
`default_nettype none
// ============================================================================
// Module   : exec_retire_stage
// Purpose  : Pipeline register after the ALU. Captures the result, computes
//            condition flags, and issues writeback requests through a
//            main + skid entry pair so the ALU keeps 1 op/cycle under
//            backpressure. Flags commit only when an op retires.
// Revision : 1.0 - initial release
// ============================================================================
module exec_retire_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  wire             clk,
    input  wire             rst_n,
    exec_retire_if.slave    bus
);

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_OR  = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b100;
    localparam logic [2:0] c_OP_SUB = 3'b101;
    localparam logic [2:0] c_OP_XOR = 3'b110;
    localparam logic [2:0] c_OP_CMP = 3'b111;

    // Main entry (drives the outputs)
    logic              main_valid_q, main_valid_d;
    logic              main_we_q,    main_we_d;
    logic [REG_AW-1:0] main_rd_q,    main_rd_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic [3:0]        main_flg_q,   main_flg_d;
    logic              main_upd_q,   main_upd_d;

    // Skid entry (holds the op accepted while main is stalled)
    logic              skid_valid_q, skid_valid_d;
    logic              skid_we_q,    skid_we_d;
    logic [REG_AW-1:0] skid_rd_q,    skid_rd_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic [3:0]        skid_flg_q,   skid_flg_d;
    logic              skid_upd_q,   skid_upd_d;

    logic              in_ready_q,   in_ready_d;
    logic [3:0]        flags_q,      flags_d;

    // Fields of the op currently offered by the ALU
    logic              w_new_we;
    logic              w_new_upd;
    logic              w_new_fc;
    logic              w_new_fo;
    logic [3:0]        w_new_flg;
    logic [DATA_W-1:0] w_add_sum;
    logic              w_a_msb;
    logic              w_b_msb;
    logic              w_r_msb;
    logic              w_accept;
    logic              w_retire;

    assign w_accept  = bus.in_valid && in_ready_q;
    assign w_retire  = main_valid_q && bus.out_ready;

    // Carry out of a+b is detected as wrap-around of the truncated sum.
    assign w_add_sum = bus.in_da + bus.in_db;
    assign w_a_msb   = bus.in_da[DATA_W-1];
    assign w_b_msb   = bus.in_db[DATA_W-1];
    assign w_r_msb   = bus.in_result[DATA_W-1];

    // Decode opcode into write-enable, flag-update and carry/overflow flags
    always_comb begin
        w_new_we  = 1'b0;
        w_new_upd = 1'b0;
        w_new_fc  = 1'b0;
        w_new_fo  = 1'b0;
        case (bus.in_inst)
            c_OP_ADD: begin
                w_new_we  = 1'b1;
                w_new_upd = 1'b1;
                w_new_fc  = (w_add_sum < bus.in_da);
                w_new_fo  = (w_a_msb == w_b_msb) && (w_r_msb != w_a_msb);
            end
            c_OP_SUB: begin
                w_new_we  = 1'b1;
                w_new_upd = 1'b1;
                w_new_fc  = (bus.in_da < bus.in_db);
                w_new_fo  = (w_a_msb != w_b_msb) && (w_r_msb != w_a_msb);
            end
            c_OP_CMP: begin
                w_new_upd = 1'b1;
                w_new_fc  = (bus.in_da < bus.in_db);
                w_new_fo  = (w_a_msb != w_b_msb) && (w_r_msb != w_a_msb);
            end
            c_OP_AND, c_OP_OR, c_OP_XOR: begin
                w_new_we  = 1'b1;
                w_new_upd = 1'b1;
            end
            default: begin
                w_new_we  = 1'b0;
                w_new_upd = 1'b0;
            end
        endcase
        w_new_flg = {(bus.in_result == '0), w_r_msb, w_new_fc, w_new_fo};
    end

    // Next-state for the two entries, the ready flag and the flags register
    always_comb begin
        main_valid_d = main_valid_q;
        main_we_d    = main_we_q;
        main_rd_d    = main_rd_q;
        main_data_d  = main_data_q;
        main_flg_d   = main_flg_q;
        main_upd_d   = main_upd_q;
        skid_valid_d = skid_valid_q;
        skid_we_d    = skid_we_q;
        skid_rd_d    = skid_rd_q;
        skid_data_d  = skid_data_q;
        skid_flg_d   = skid_flg_q;
        skid_upd_d   = skid_upd_q;
        flags_d      = flags_q;

        if (w_retire && main_upd_q) begin
            flags_d = main_flg_q;
        end

        // Accept cannot coincide with a full skid since in_ready is low then.
        if (w_retire && skid_valid_q) begin
            main_valid_d = 1'b1;
            main_we_d    = skid_we_q;
            main_rd_d    = skid_rd_q;
            main_data_d  = skid_data_q;
            main_flg_d   = skid_flg_q;
            main_upd_d   = skid_upd_q;
            skid_valid_d = 1'b0;
        end else if (w_accept && (!main_valid_q || w_retire)) begin
            main_valid_d = 1'b1;
            main_we_d    = w_new_we;
            main_rd_d    = bus.in_rd;
            main_data_d  = bus.in_result;
            main_flg_d   = w_new_flg;
            main_upd_d   = w_new_upd;
        end else if (w_accept) begin
            skid_valid_d = 1'b1;
            skid_we_d    = w_new_we;
            skid_rd_d    = bus.in_rd;
            skid_data_d  = bus.in_result;
            skid_flg_d   = w_new_flg;
            skid_upd_d   = w_new_upd;
        end else if (w_retire) begin
            // Payload holds; only the valid bit drops.
            main_valid_d = 1'b0;
        end

        in_ready_d = !skid_valid_d;
    end

    // State registers; reset discards both entries and clears the flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_we_q    <= 1'b0;
            main_rd_q    <= '0;
            main_data_q  <= '0;
            main_flg_q   <= 4'b0000;
            main_upd_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_we_q    <= 1'b0;
            skid_rd_q    <= '0;
            skid_data_q  <= '0;
            skid_flg_q   <= 4'b0000;
            skid_upd_q   <= 1'b0;
            in_ready_q   <= 1'b1;
            flags_q      <= 4'b0000;
        end else begin
            main_valid_q <= main_valid_d;
            main_we_q    <= main_we_d;
            main_rd_q    <= main_rd_d;
            main_data_q  <= main_data_d;
            main_flg_q   <= main_flg_d;
            main_upd_q   <= main_upd_d;
            skid_valid_q <= skid_valid_d;
            skid_we_q    <= skid_we_d;
            skid_rd_q    <= skid_rd_d;
            skid_data_q  <= skid_data_d;
            skid_flg_q   <= skid_flg_d;
            skid_upd_q   <= skid_upd_d;
            in_ready_q   <= in_ready_d;
            flags_q      <= flags_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = main_valid_q;
    assign bus.out_we    = main_we_q;
    assign bus.out_rd    = main_rd_q;
    assign bus.out_data  = main_data_q;
    assign bus.flags     = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_exec_retire_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_exec_retire_stage
// Purpose  : Directed self-checking bench for exec_retire_stage. Inputs are
//            driven and outputs sampled on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exec_retire_stage;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    exec_retire_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

    exec_retire_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_op(input logic [2:0] inst, input logic [31:0] da,
                            input logic [31:0] db, input logic [31:0] res,
                            input logic [4:0] rd);
        bus.in_valid  = 1'b1;
        bus.in_inst   = inst;
        bus.in_da     = da;
        bus.in_db     = db;
        bus.in_result = res;
        bus.in_rd     = rd;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b want 0", bus.out_valid); end
        checks++; if (bus.out_we !== 1'b0) begin errors++; $display("FAIL rst_we got %0b want 0", bus.out_we); end
        checks++; if (bus.out_rd !== 5'd0) begin errors++; $display("FAIL rst_rd got %0d want 0", bus.out_rd); end
        checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL rst_data got %h want 0", bus.out_data); end
        checks++; if (bus.flags !== 4'b0000) begin errors++; $display("FAIL rst_flags got %b want 0000", bus.flags); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0b want 1", bus.in_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_rel_in_ready got %0b want 1", bus.in_ready); end
    endtask

    task automatic test_add();
        bus.out_ready = 1'b1;
        drive_op(3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 5'd3);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %0b want 1", bus.out_valid); end
        checks++; if (bus.out_we !== 1'b1) begin errors++; $display("FAIL add_we got %0b want 1", bus.out_we); end
        checks++; if (bus.out_rd !== 5'd3) begin errors++; $display("FAIL add_rd got %0d want 3", bus.out_rd); end
        checks++; if (bus.out_data !== 32'h8000_0000) begin errors++; $display("FAIL add_data got %h want 80000000", bus.out_data); end
        checks++; if (bus.flags !== 4'b0000) begin errors++; $display("FAIL add_flags_pre got %b want 0000", bus.flags); end
        @(negedge clk);
        checks++; if (bus.flags !== 4'b0101) begin errors++; $display("FAIL add_flags got %b want 0101", bus.flags); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL add_retired got %0b want 0", bus.out_valid); end
    endtask

    task automatic test_cmp();
        bus.out_ready = 1'b1;
        drive_op(3'b111, 32'd5, 32'd5, 32'd0, 5'd7);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL cmp_valid got %0b want 1", bus.out_valid); end
        checks++; if (bus.out_we !== 1'b0) begin errors++; $display("FAIL cmp_we got %0b want 0", bus.out_we); end
        @(negedge clk);
        checks++; if (bus.flags !== 4'b1000) begin errors++; $display("FAIL cmp_flags got %b want 1000", bus.flags); end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        drive_op(3'b101, 32'h0, 32'h1, 32'hFFFF_FFFF, 5'd1);
        @(negedge clk);
        checks++; if (bus.out_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL b2b_sub_data got %h want ffffffff", bus.out_data); end
        drive_op(3'b110, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0, 5'd2);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if (bus.flags !== 4'b0110) begin errors++; $display("FAIL b2b_sub_flags got %b want 0110", bus.flags); end
        checks++; if (bus.out_valid !== 1'b1 || bus.out_rd !== 5'd2) begin errors++; $display("FAIL b2b_xor_out got valid=%0b rd=%0d want valid=1 rd=2", bus.out_valid, bus.out_rd); end
        @(negedge clk);
        checks++; if (bus.flags !== 4'b1000) begin errors++; $display("FAIL b2b_xor_flags got %b want 1000", bus.flags); end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        drive_op(3'b000, 32'd1, 32'd2, 32'd3, 5'd10);
        @(negedge clk);
        drive_op(3'b001, 32'h10, 32'h01, 32'h11, 5'd11);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_a got %0b want 1", bus.in_ready); end
        @(negedge clk);
        drive_op(3'b100, 32'h8000_0001, 32'h8000_0000, 32'h8000_0000, 5'd12);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_b got %0b want 0", bus.in_ready); end
        checks++; if (bus.out_rd !== 5'd10 || bus.out_data !== 32'd3) begin errors++; $display("FAIL bp_stall1 got rd=%0d data=%h want rd=10 data=3", bus.out_rd, bus.out_data); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_rd !== 5'd10 || bus.out_data !== 32'd3) begin errors++; $display("FAIL bp_stall2 got v=%0b rd=%0d data=%h want v=1 rd=10 data=3", bus.out_valid, bus.out_rd, bus.out_data); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_c_held got %0b want 0", bus.in_ready); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.out_rd !== 5'd11 || bus.out_data !== 32'h11) begin errors++; $display("FAIL bp_order_b got rd=%0d data=%h want rd=11 data=11", bus.out_rd, bus.out_data); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got %0b want 1", bus.in_ready); end
        checks++; if (bus.flags !== 4'b0000) begin errors++; $display("FAIL bp_flags_a got %b want 0000", bus.flags); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_rd !== 5'd12) begin errors++; $display("FAIL bp_order_c got v=%0b rd=%0d want v=1 rd=12", bus.out_valid, bus.out_rd); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %0b want 0", bus.out_valid); end
        checks++; if (bus.flags !== 4'b0100) begin errors++; $display("FAIL bp_flags_c got %b want 0100", bus.flags); end
    endtask

    task automatic test_undefined();
        bus.out_ready = 1'b1;
        drive_op(3'b000, 32'd1, 32'd1, 32'd2, 5'd4);
        @(negedge clk);
        drive_op(3'b010, 32'd0, 32'd0, 32'd0, 5'd5);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if (bus.flags !== 4'b0000) begin errors++; $display("FAIL undef_add_flags got %b want 0000", bus.flags); end
        checks++; if (bus.out_valid !== 1'b1 || bus.out_we !== 1'b0 || bus.out_rd !== 5'd5) begin errors++; $display("FAIL undef_out got v=%0b we=%0b rd=%0d want v=1 we=0 rd=5", bus.out_valid, bus.out_we, bus.out_rd); end
        @(negedge clk);
        checks++; if (bus.flags !== 4'b0000) begin errors++; $display("FAIL undef_flags_hold got %b want 0000", bus.flags); end
    endtask

    task automatic test_reset_midstall();
        bus.out_ready = 1'b1;
        drive_op(3'b101, 32'h0, 32'h1, 32'hFFFF_FFFF, 5'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.flags !== 4'b0110) begin errors++; $display("FAIL mrst_pre_flags got %b want 0110", bus.flags); end
        bus.out_ready = 1'b0;
        drive_op(3'b000, 32'd2, 32'd2, 32'd4, 5'd8);
        @(negedge clk);
        drive_op(3'b000, 32'd3, 32'd3, 32'd6, 5'd9);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL mrst_stalled got rdy=%0b v=%0b want rdy=0 v=1", bus.in_ready, bus.out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid got %0b want 0", bus.out_valid); end
        checks++; if (bus.flags !== 4'b0000) begin errors++; $display("FAIL mrst_flags got %b want 0000", bus.flags); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mrst_ready got %0b want 1", bus.in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mrst_stale got %0b want 0", bus.out_valid); end
        checks++; if (bus.flags !== 4'b0000) begin errors++; $display("FAIL mrst_flags_after got %b want 0000", bus.flags); end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_inst   = 3'b000;
        bus.in_da     = '0;
        bus.in_db     = '0;
        bus.in_result = '0;
        bus.in_rd     = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_add();
        test_cmp();
        test_back_to_back();
        test_backpressure();
        test_undefined();
        test_reset_midstall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
